// File: rtl/rom_dumper.sv
// rom_dumper: streams DUMP_WORDS 32-bit memory words out as bytes, least significant byte first.
// Latency: one dump takes 6 cycles per word (READ, LATCH, 4x SEND) plus FIN when tx_ready stays high.
// Backpressure: tx_data is held stable in SEND/CSUM until tx_ready accepts it; a stalled byte simply waits.
// Ports: clk/rst (sync, active-high); start -> busy/done; mem_ren/mem_addr/mem_rdata (read data
//        returned one cycle after mem_ren); tx_data/tx_valid/tx_ready (byte stream to the UART).
// Option: define ROM_DUMPER_CHECKSUM_EN to append a two's-complement checksum byte to each dump.
module rom_dumper #(
    parameter int ADDR_WIDTH = 14,
    parameter int DUMP_WORDS = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(DUMP_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
`ifdef ROM_DUMPER_CHECKSUM_EN
        CSUM,
`endif
        FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]              idx_q, idx_d;
    logic [31:0]             hold_q, hold_d;
    logic [31:0]             hold_shift;
`ifdef ROM_DUMPER_CHECKSUM_EN
    logic [7:0]              sum_q, sum_d;
`endif

    // The counter doubles as the read address: it only moves on start or when
    // the next word is fetched, so the address holds between reads.
    assign mem_addr   = cnt_q;
    assign hold_shift = hold_q >> {idx_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
`ifdef ROM_DUMPER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        busy     = 1'b0;
        done     = 1'b0;
        mem_ren  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    cnt_d   = '0;
`ifdef ROM_DUMPER_CHECKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            READ: begin
                busy    = 1'b1;
                mem_ren = 1'b1;
                state_d = LATCH;
            end
            LATCH: begin
                busy    = 1'b1;
                hold_d  = mem_rdata;
                idx_d   = 2'd0;
                state_d = SEND;
            end
            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = hold_shift[7:0];
                if (tx_ready) begin
`ifdef ROM_DUMPER_CHECKSUM_EN
                    sum_d = sum_q + hold_shift[7:0];
`endif
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (cnt_q != LAST_CNT) begin
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                        state_d = READ;
                    end else begin
`ifdef ROM_DUMPER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = FIN;
`endif
                    end
                end
            end
`ifdef ROM_DUMPER_CHECKSUM_EN
            CSUM: begin
                // Negated sum makes the byte total of the whole dump 0 mod 256.
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = 8'h00 - sum_q;
                if (tx_ready) begin
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                // start is deliberately not looked at here; only IDLE accepts it.
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            hold_q  <= 32'h0;
`ifdef ROM_DUMPER_CHECKSUM_EN
            sum_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
`ifdef ROM_DUMPER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

endmodule
